keyboard_matrix_gen: RTL and testbench
======================================

KEYBOARD_MATRIX_GEN -- requirements
Module: keyboard_matrix_gen

Interface
REQ-001 Parameter NROWS, default 10: number of matrix rows, 1..16.
REQ-002 Parameter NCOLS, default 6: number of matrix columns, 1..8.
REQ-003 Parameter ROWW, default 4: ROW select width; 2**ROWW >= NROWS.
REQ-004 Parameter TIMEOUT, default 1048576: idle cycles after which a partial prefix sequence is abandoned.
REQ-005 Parameter BREAK_PULSE, default 65536: BREAK_OUT low time in cycles for the Pause key.
REQ-006 CLK  in  1  system clock; single clock domain.
REQ-007 nRESET  in  1  reset, asynchronous, active-low.
REQ-008 PS2_CLK, PS2_DATA  in  1 each  raw PS/2 lines.
REQ-009 ROW  in  ROWW  row select.
REQ-010 KEYOUT  out  NCOLS  active-low column state of the selected row.
REQ-011 SHIFT_OUT, CTRL_OUT, REPEAT_OUT, BREAK_OUT  out  1 each  active-low modifiers.
REQ-012 TURBO  out  2  CPU speed select.
REQ-013 ERR_CNT  out  8  saturating count of PS/2 frame errors.

Function
REQ-014 Decoder FSM states: IDLE, E0, F0, E0F0, SKIP; transitions on each valid byte only.
REQ-015 IDLE: E0->E0; F0->F0; E1->SKIP with skip count 7 and Pause event; other byte->make event (ext=0), stay IDLE.
REQ-016 E0: F0->E0F0; other->make event (ext=1), ->IDLE.
REQ-017 F0: any byte->break event (ext=0), ->IDLE; E0F0: any byte->break event (ext=1), ->IDLE.
REQ-018 SKIP: discard bytes, decrement count, ->IDLE when count reaches 0.
REQ-019 Event applies one cycle after the terminating byte's VALID: mapped matrix bit <= 0 on make, 1 on break.
REQ-020 Lookup keyed on {ext, code}; unmapped codes or row>=NROWS or col>=NCOLS are ignored with no state change.
REQ-021 ext=1 codes 12/59 (fake shifts) are ignored; 12/59 with ext=0 drive SHIFT_OUT; 14 (either ext) drives CTRL_OUT; 11 ext=0 drives REPEAT_OUT.
REQ-022 Make of F1/F2/F3/F4 (05/06/04/0C) sets TURBO to 0/1/2/3; break of these has no effect.
REQ-023 F10 (09) drives BREAK_OUT level-wise; Pause event drives BREAK_OUT low for exactly BREAK_PULSE cycles, then high unless F10 is held.
REQ-024 KEYOUT is combinational from ROW; ROW >= NROWS returns all ones.
REQ-025 Frame error: FSM->IDLE, partial byte discarded, ERR_CNT +1, saturating at 255.
REQ-026 Idle counter resets on every valid byte; in E0/F0/E0F0/SKIP reaching TIMEOUT forces IDLE; no effect in IDLE.
REQ-027 Error and valid in the same cycle: error wins, byte is discarded.
REQ-028 Three consecutive errors with no valid byte between them release all keys and modifiers (all ones; TURBO held).

Reset
REQ-029 nRESET low, asynchronously: FSM IDLE, all matrix bits 1, SHIFT/CTRL/REPEAT/BREAK_OUT 1, TURBO 00, ERR_CNT 0, counters 0.
REQ-030 Reset mid-sequence discards the partial sequence; the first byte after release is decoded from IDLE.

Structure
REQ-031 Shared package keyboard_pkg holds FSM state encodings, prefix constants (E0, F0, E1), modifier/turbo scancodes and the {ext,code}->{hit,row,col} mapping function.
REQ-032 Sub-module ps2_intf (existing) supplies DATA/VALID/error; the decoder FSM and matrix are contained in this block.

Verification
REQ-033 Send 1C then F0 1C -> keys row6 col3 low after make, high after break; other bits unchanged.
REQ-034 Send E0 12 then 12 -> SHIFT_OUT stays 1 after E0 12, goes 0 after plain 12.
REQ-035 Send E1 14 77 E1 F0 14 F0 77 -> no matrix/CTRL change; BREAK_OUT low BREAK_PULSE cycles exactly.
REQ-036 Send E0, wait TIMEOUT cycles, send 75 -> treated as ext=0 make (row2 col0 low).
REQ-037 Inject 3 parity errors while A held -> ERR_CNT=3, all KEYOUT ones, SHIFT_OUT 1.
REQ-038 Set NROWS=8, send 29 (maps to row9) -> ignored; assert nRESET mid F0 then send 1C -> make of A.

Source files
------------

// File: rtl/keyboard_pkg.sv
// Shared decoder definitions: FSM states, PS/2 prefix and modifier scancodes,
// and the {ext,code} -> matrix position lookup.
package keyboard_pkg;

  typedef enum logic [2:0] {S_IDLE, S_E0, S_F0, S_E0F0, S_SKIP} dec_state_t;

  localparam logic [7:0] PFX_E0 = 8'hE0;
  localparam logic [7:0] PFX_F0 = 8'hF0;
  localparam logic [7:0] PFX_E1 = 8'hE1;

  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_ALT    = 8'h11;
  localparam logic [7:0] SC_F10    = 8'h09;
  localparam logic [7:0] SC_F1     = 8'h05;
  localparam logic [7:0] SC_F2     = 8'h06;
  localparam logic [7:0] SC_F3     = 8'h04;
  localparam logic [7:0] SC_F4     = 8'h0C;

  // Bytes following E1 in the Pause make sequence
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef struct packed {
    logic       hit;
    logic [3:0] row;
    logic [2:0] col;
  } key_map_t;

  function automatic key_map_t key_map(input logic ext, input logic [7:0] code);
    key_map_t m;
    m = '0;
    case ({ext, code})
      9'h045: m = '{1'b1, 4'd0, 3'd0};
      9'h046: m = '{1'b1, 4'd0, 3'd1};
      9'h03E: m = '{1'b1, 4'd1, 3'd0};
      9'h03D: m = '{1'b1, 4'd1, 3'd1};
      9'h075: m = '{1'b1, 4'd2, 3'd0};
      9'h175: m = '{1'b1, 4'd2, 3'd1};
      9'h172: m = '{1'b1, 4'd2, 3'd2};
      9'h16B: m = '{1'b1, 4'd2, 3'd3};
      9'h174: m = '{1'b1, 4'd2, 3'd4};
      9'h02B: m = '{1'b1, 4'd5, 3'd0};
      9'h01A: m = '{1'b1, 4'd5, 3'd1};
      9'h022: m = '{1'b1, 4'd5, 3'd2};
      9'h01C: m = '{1'b1, 4'd6, 3'd3};
      9'h01B: m = '{1'b1, 4'd6, 3'd4};
      9'h023: m = '{1'b1, 4'd6, 3'd5};
      9'h015: m = '{1'b1, 4'd7, 3'd0};
      9'h01D: m = '{1'b1, 4'd7, 3'd1};
      9'h024: m = '{1'b1, 4'd7, 3'd2};
      9'h016: m = '{1'b1, 4'd8, 3'd0};
      9'h01E: m = '{1'b1, 4'd8, 3'd1};
      9'h029: m = '{1'b1, 4'd9, 3'd0};
      9'h05A: m = '{1'b1, 4'd9, 3'd1};
      9'h066: m = '{1'b1, 4'd9, 3'd2};
      9'h076: m = '{1'b1, 4'd9, 3'd3};
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/keyboard_matrix_gen_if.sv
// Host-side matrix bus: row select in, column state and modifier lines out.
interface keyboard_matrix_gen_if #(
  parameter int ROWW  = 4,
  parameter int NCOLS = 6
);
  logic [ROWW-1:0]  ROW;
  logic [NCOLS-1:0] KEYOUT;
  logic             SHIFT_OUT;
  logic             CTRL_OUT;
  logic             REPEAT_OUT;
  logic             BREAK_OUT;
  logic [1:0]       TURBO;
  logic [7:0]       ERR_CNT;

  modport master (output ROW, input KEYOUT, SHIFT_OUT, CTRL_OUT, REPEAT_OUT,
                  BREAK_OUT, TURBO, ERR_CNT);
  modport slave  (input ROW, output KEYOUT, SHIFT_OUT, CTRL_OUT, REPEAT_OUT,
                  BREAK_OUT, TURBO, ERR_CNT);
endinterface

// File: rtl/ps2_intf.sv
// PS/2 device-to-host receiver: 11-bit frames sampled on falling PS2 clock,
// odd parity; one-cycle valid or error strobe per frame.
module ps2_intf #(
  parameter int RX_IDLE = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data,
  output logic       valid,
  output logic       error
);
  localparam int GW = $clog2(RX_IDLE + 1);

  logic [1:0]    clk_sync, dat_sync;
  logic          clk_d, fall;
  logic [3:0]    bit_cnt;
  logic [8:0]    shreg;
  logic [GW-1:0] gap;

  assign fall = clk_d & ~clk_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_d    <= 1'b1;
      bit_cnt  <= '0;
      shreg    <= '0;
      gap      <= '0;
      data     <= '0;
      valid    <= 1'b0;
      error    <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      clk_d    <= clk_sync[1];
      valid    <= 1'b0;
      error    <= 1'b0;
      if (fall) begin
        gap <= '0;
        if (bit_cnt == 4'd0) begin
          if (!dat_sync[1]) bit_cnt <= 4'd1;
        end else if (bit_cnt == 4'd10) begin
          bit_cnt <= '0;
          if (dat_sync[1] && ^shreg) begin
            valid <= 1'b1;
            data  <= shreg[7:0];
          end else begin
            error <= 1'b1;
          end
        end else begin
          shreg   <= {dat_sync[1], shreg[8:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (bit_cnt != 4'd0) begin
        // A stalled device clock mid-frame drops the partial frame silently
        if (gap == GW'(RX_IDLE)) bit_cnt <= '0;
        else                     gap     <= gap + 1'b1;
      end
    end
  end
endmodule

// File: rtl/keyboard_matrix_gen.sv
// PS/2 scancode decoder driving an active-low key matrix plus modifier,
// turbo and break lines for a host that scans rows.
module keyboard_matrix_gen import keyboard_pkg::*; #(
  parameter int NROWS       = 10,
  parameter int NCOLS       = 6,
  parameter int ROWW        = 4,
  parameter int TIMEOUT     = 1048576,
  parameter int BREAK_PULSE = 65536
) (
  input  logic CLK,
  input  logic nRESET,
  input  logic PS2_CLK,
  input  logic PS2_DATA,
  keyboard_matrix_gen_if.slave kbd
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int PW = $clog2(BREAK_PULSE + 1);

  logic [7:0] rx_data;
  logic       rx_vld, rx_err;

  ps2_intf u_rx (
    .clk     (CLK),
    .rst_n   (nRESET),
    .ps2_clk (PS2_CLK),
    .ps2_data(PS2_DATA),
    .data    (rx_data),
    .valid   (rx_vld),
    .error   (rx_err)
  );

  dec_state_t state, state_nxt;
  logic [2:0] skip_cnt, skip_nxt;
  logic       ev, ev_ext, ev_brk, ev_pause;
  logic [TW-1:0] idle_cnt;
  logic [PW-1:0] pulse_cnt;
  logic [NROWS-1:0][NCOLS-1:0] mtx;
  logic       lshift, rshift, ctrl_l, ctrl_r, rpt, f10;
  logic [1:0] turbo;
  logic [7:0] err_cnt;
  logic [1:0] err_run;
  logic [NCOLS-1:0] keyout;
  key_map_t   km;

  assign km = key_map(ev_ext, rx_data);

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state    <= S_IDLE;
      skip_cnt <= '0;
    end else begin
      state    <= state_nxt;
      skip_cnt <= skip_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    skip_nxt  = skip_cnt;
    ev        = 1'b0;
    ev_ext    = 1'b0;
    ev_brk    = 1'b0;
    ev_pause  = 1'b0;
    if (rx_err) begin
      state_nxt = S_IDLE;
    end else if (rx_vld) begin
      case (state)
        S_IDLE: begin
          if (rx_data == PFX_E0)      state_nxt = S_E0;
          else if (rx_data == PFX_F0) state_nxt = S_F0;
          else if (rx_data == PFX_E1) begin
            state_nxt = S_SKIP;
            skip_nxt  = PAUSE_SKIP;
            ev_pause  = 1'b1;
          end else ev = 1'b1;
        end
        S_E0: begin
          if (rx_data == PFX_F0) state_nxt = S_E0F0;
          else begin
            ev        = 1'b1;
            ev_ext    = 1'b1;
            state_nxt = S_IDLE;
          end
        end
        S_F0: begin
          ev        = 1'b1;
          ev_brk    = 1'b1;
          state_nxt = S_IDLE;
        end
        S_E0F0: begin
          ev        = 1'b1;
          ev_brk    = 1'b1;
          ev_ext    = 1'b1;
          state_nxt = S_IDLE;
        end
        S_SKIP: begin
          skip_nxt = skip_cnt - 3'd1;
          if (skip_cnt == 3'd1) state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end else if (state != S_IDLE && idle_cnt == TW'(TIMEOUT)) begin
      state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) idle_cnt <= '0;
    else if (rx_vld) idle_cnt <= '0;
    else if (idle_cnt != TW'(TIMEOUT)) idle_cnt <= idle_cnt + 1'b1;
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      mtx       <= '1;
      lshift    <= 1'b1;
      rshift    <= 1'b1;
      ctrl_l    <= 1'b1;
      ctrl_r    <= 1'b1;
      rpt       <= 1'b1;
      f10       <= 1'b1;
      turbo     <= 2'd0;
      err_cnt   <= '0;
      err_run   <= '0;
      pulse_cnt <= '0;
    end else begin
      if (pulse_cnt != '0) pulse_cnt <= pulse_cnt - 1'b1;
      if (rx_err) begin
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        if (err_run != 2'd3)  err_run <= err_run + 2'd1;
        // Line looks dead: drop everything held so the host sees no stuck keys
        if (err_run >= 2'd2) begin
          mtx       <= '1;
          lshift    <= 1'b1;
          rshift    <= 1'b1;
          ctrl_l    <= 1'b1;
          ctrl_r    <= 1'b1;
          rpt       <= 1'b1;
          f10       <= 1'b1;
          pulse_cnt <= '0;
        end
      end else if (rx_vld) begin
        err_run <= '0;
        if (ev_pause) pulse_cnt <= PW'(BREAK_PULSE);
        if (ev) begin
          if (!ev_ext && rx_data == SC_LSHIFT)      lshift <= ev_brk;
          else if (!ev_ext && rx_data == SC_RSHIFT) rshift <= ev_brk;
          else if (rx_data == SC_CTRL) begin
            if (ev_ext) ctrl_r <= ev_brk;
            else        ctrl_l <= ev_brk;
          end
          else if (!ev_ext && rx_data == SC_ALT)    rpt    <= ev_brk;
          else if (!ev_ext && rx_data == SC_F10)    f10    <= ev_brk;
          else if (!ev_ext && (rx_data == SC_F1 || rx_data == SC_F2 ||
                               rx_data == SC_F3 || rx_data == SC_F4)) begin
            if (!ev_brk) begin
              case (rx_data)
                SC_F1:   turbo <= 2'd0;
                SC_F2:   turbo <= 2'd1;
                SC_F3:   turbo <= 2'd2;
                default: turbo <= 2'd3;
              endcase
            end
          end else if (km.hit) begin
            // Positions outside NROWS x NCOLS never match and are dropped
            for (int r = 0; r < NROWS; r++)
              for (int c = 0; c < NCOLS; c++)
                if (km.row == 4'(r) && km.col == 3'(c)) mtx[r][c] <= ev_brk;
          end
        end
      end
    end
  end

  always_comb begin
    keyout = '1;
    for (int r = 0; r < NROWS; r++)
      if (kbd.ROW == ROWW'(r)) keyout = mtx[r];
  end

  assign kbd.KEYOUT     = keyout;
  assign kbd.SHIFT_OUT  = lshift & rshift;
  assign kbd.CTRL_OUT   = ctrl_l & ctrl_r;
  assign kbd.REPEAT_OUT = rpt;
  assign kbd.BREAK_OUT  = f10 & (pulse_cnt == '0);
  assign kbd.TURBO      = turbo;
  assign kbd.ERR_CNT    = err_cnt;
endmodule

// File: tb/tb_keyboard_matrix_gen.sv
// Directed bench: two instances (10 and 8 rows) fed the same PS/2 stream.
module tb_keyboard_matrix_gen;
  localparam int TO = 1000;
  localparam int BP = 20;

  logic clk = 1'b0, rst_n = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
  always #5 clk = ~clk;

  keyboard_matrix_gen_if #(.ROWW(4), .NCOLS(6)) kb0 ();
  keyboard_matrix_gen_if #(.ROWW(4), .NCOLS(6)) kb1 ();

  keyboard_matrix_gen #(.NROWS(10), .NCOLS(6), .ROWW(4), .TIMEOUT(TO), .BREAK_PULSE(BP)) u0 (
    .CLK(clk), .nRESET(rst_n), .PS2_CLK(ps2_clk), .PS2_DATA(ps2_data), .kbd(kb0));
  keyboard_matrix_gen #(.NROWS(8), .NCOLS(6), .ROWW(4), .TIMEOUT(TO), .BREAK_PULSE(BP)) u1 (
    .CLK(clk), .nRESET(rst_n), .PS2_CLK(ps2_clk), .PS2_DATA(ps2_data), .kbd(kb1));

  int n_chk = 0, n_fail = 0;
  int brk_low = 0;
  logic [5:0] m [10];

  always @(negedge clk) if (kb0.BREAK_OUT === 1'b0) brk_low <= brk_low + 1;

  typedef struct { bit ext; bit brk; logic [7:0] code; int row; int col; } vec_t;
  vec_t vt [14];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input bit bad = 1'b0);
    logic [10:0] f;
    f = {1'b1, (bad ? ^b : ~^b), b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2_data = f[i];
      cyc(4);
      ps2_clk = 1'b0;
      cyc(4);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    cyc(8);
  endtask

  task automatic check_keys(input string tag);
    for (int r = 0; r < 16; r++) begin
      logic [5:0] e0, e1;
      e0 = 6'h3F;
      e1 = 6'h3F;
      if (r < 10) e0 = m[r];
      if (r < 8)  e1 = m[r];
      kb0.ROW = 4'(r);
      kb1.ROW = 4'(r);
      #1;
      chk($sformatf("%s n10 row%0d", tag, r), 32'(kb0.KEYOUT), 32'(e0));
      chk($sformatf("%s n8 row%0d", tag, r), 32'(kb1.KEYOUT), 32'(e1));
    end
  endtask

  task automatic check_mods(input string tag, input logic sh, input logic ct, input logic rp,
                            input logic bk, input logic [1:0] tb);
    chk({tag, " shift"},  32'(kb0.SHIFT_OUT),  32'(sh));
    chk({tag, " ctrl"},   32'(kb0.CTRL_OUT),   32'(ct));
    chk({tag, " repeat"}, 32'(kb0.REPEAT_OUT), 32'(rp));
    chk({tag, " break"},  32'(kb0.BREAK_OUT),  32'(bk));
    chk({tag, " turbo"},  32'(kb0.TURBO),      32'(tb));
  endtask

  task automatic send_pause();
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
  endtask

  initial begin
    int b0;
    vt[0]  = '{1'b0, 1'b0, 8'h1C, 6, 3};
    vt[1]  = '{1'b0, 1'b1, 8'h1C, 6, 3};
    vt[2]  = '{1'b0, 1'b0, 8'h29, 9, 0};
    vt[3]  = '{1'b1, 1'b0, 8'h75, 2, 1};
    vt[4]  = '{1'b0, 1'b0, 8'h75, 2, 0};
    vt[5]  = '{1'b1, 1'b1, 8'h75, 2, 1};
    vt[6]  = '{1'b0, 1'b1, 8'h75, 2, 0};
    vt[7]  = '{1'b0, 1'b1, 8'h29, 9, 0};
    vt[8]  = '{1'b0, 1'b0, 8'h5A, 9, 1};
    vt[9]  = '{1'b0, 1'b0, 8'h45, 0, 0};
    vt[10] = '{1'b0, 1'b0, 8'h0E, -1, -1};
    vt[11] = '{1'b1, 1'b0, 8'h1C, -1, -1};
    vt[12] = '{1'b0, 1'b1, 8'h5A, 9, 1};
    vt[13] = '{1'b0, 1'b1, 8'h45, 0, 0};
    for (int r = 0; r < 10; r++) m[r] = 6'h3F;
    kb0.ROW = '0;
    kb1.ROW = '0;

    cyc(3);
    check_keys("reset");
    check_mods("reset", 1, 1, 1, 1, 2'd0);
    chk("reset errcnt", 32'(kb0.ERR_CNT), 32'd0);
    rst_n = 1'b1;
    cyc(3);

    for (int i = 0; i < 14; i++) begin
      if (vt[i].ext) send(8'hE0);
      if (vt[i].brk) send(8'hF0);
      send(vt[i].code);
      if (vt[i].row >= 0) m[vt[i].row][vt[i].col] = vt[i].brk;
      check_keys($sformatf("vec%0d", i));
    end

    // Modifiers
    send(8'hE0); send(8'h12);
    check_mods("fake shift", 1, 1, 1, 1, 2'd0);
    send(8'h12);
    check_mods("lshift make", 0, 1, 1, 1, 2'd0);
    send(8'h59); send(8'hF0); send(8'h12);
    check_mods("rshift held", 0, 1, 1, 1, 2'd0);
    send(8'hF0); send(8'h59);
    check_mods("shifts up", 1, 1, 1, 1, 2'd0);
    send(8'h14);
    check_mods("lctrl make", 1, 0, 1, 1, 2'd0);
    send(8'hF0); send(8'h14);
    send(8'hE0); send(8'h14);
    check_mods("rctrl make", 1, 0, 1, 1, 2'd0);
    send(8'hE0); send(8'hF0); send(8'h14);
    send(8'h11);
    check_mods("alt make", 1, 1, 0, 1, 2'd0);
    send(8'hF0); send(8'h11);
    send(8'h09);
    check_mods("f10 make", 1, 1, 1, 0, 2'd0);
    send(8'hF0); send(8'h09);
    check_mods("f10 break", 1, 1, 1, 1, 2'd0);
    check_keys("mods");

    // Turbo
    send(8'h06); chk("turbo f2", 32'(kb0.TURBO), 32'd1);
    send(8'h0C); chk("turbo f4", 32'(kb0.TURBO), 32'd3);
    send(8'hF0); send(8'h0C); chk("turbo f4 break", 32'(kb0.TURBO), 32'd3);
    send(8'h05); chk("turbo f1", 32'(kb0.TURBO), 32'd0);
    send(8'h04); chk("turbo f3", 32'(kb0.TURBO), 32'd2);
    check_keys("turbo");

    // Pause
    b0 = brk_low;
    send_pause();
    chk("pause low cycles", 32'(brk_low - b0), 32'(BP));
    check_mods("pause", 1, 1, 1, 1, 2'd2);
    check_keys("pause");
    send(8'h1C); m[6][3] = 1'b0;
    check_keys("after pause");
    send(8'hF0); send(8'h1C); m[6][3] = 1'b1;
    send(8'h09);
    send_pause();
    check_mods("pause f10 held", 1, 1, 1, 0, 2'd2);
    send(8'hF0); send(8'h09);
    check_mods("f10 released", 1, 1, 1, 1, 2'd2);

    // Prefix timeout
    send(8'hE0); cyc(TO - 200); send(8'h75); m[2][1] = 1'b0;
    check_keys("e0 in time");
    send(8'hE0); send(8'hF0); send(8'h75); m[2][1] = 1'b1;
    send(8'hE0); cyc(TO + 50); send(8'h75); m[2][0] = 1'b0;
    check_keys("e0 timeout");
    send(8'hF0); send(8'h75); m[2][0] = 1'b1;

    // Frame errors
    send(8'h1C); m[6][3] = 1'b0;
    send(8'h12);
    send(8'h00, 1'b1);
    send(8'h00, 1'b1);
    chk("err two", 32'(kb0.ERR_CNT), 32'd2);
    check_keys("err two held");
    check_mods("err two", 0, 1, 1, 1, 2'd2);
    send(8'h00, 1'b1);
    for (int r = 0; r < 10; r++) m[r] = 6'h3F;
    chk("err three", 32'(kb0.ERR_CNT), 32'd3);
    check_keys("err release");
    check_mods("err release", 1, 1, 1, 1, 2'd2);
    send(8'hE0); send(8'hE0, 1'b1); send(8'h75); m[2][0] = 1'b0;
    check_keys("err drops prefix");
    send(8'hF0); send(8'h75); m[2][0] = 1'b1;
    send(8'h1C); m[6][3] = 1'b0;
    send(8'h00, 1'b1); send(8'h00, 1'b1);
    send(8'h29); m[9][0] = 1'b0;
    send(8'h00, 1'b1);
    chk("err run broken cnt", 32'(kb0.ERR_CNT), 32'd7);
    check_keys("err run broken");
    for (int i = 0; i < 250; i++) send(8'h55, 1'b1);
    for (int r = 0; r < 10; r++) m[r] = 6'h3F;
    chk("err sat n10", 32'(kb0.ERR_CNT), 32'd255);
    chk("err sat n8", 32'(kb1.ERR_CNT), 32'd255);

    // Reset in the middle of a break sequence
    send(8'hF0);
    rst_n = 1'b0;
    cyc(2);
    check_mods("midreset", 1, 1, 1, 1, 2'd0);
    chk("midreset errcnt", 32'(kb0.ERR_CNT), 32'd0);
    rst_n = 1'b1;
    cyc(2);
    send(8'h1C); m[6][3] = 1'b0;
    check_keys("post reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
